// File: rtl/afe_seq_ctl.sv
// Parametrised AFE readout sequencer: IRST/STI, channel clock-out, SHR, INTG/TFT/DF_SM, SHS per line.
// Optional chain shift-out check enabled by defining AFE_SEQ_STO_CHECK_EN.
module afe_seq_ctl #(
   parameter int CH_NUM      = 64,
   parameter int AFE_NUM     = 2,
   parameter int T_SXX       = 5,
   parameter int T_IRST      = 10,
   parameter int T_HALF_CLK  = 65,
   parameter int T_WAIT_INTG = 10,
   parameter int T_TFT       = 1400,
   parameter int T_INTG      = 1420,
   parameter int T_WAIT_SHS  = 500,
   parameter int T_END       = 10,
   parameter int CNT_W       = 16
) (
   input  logic        CLK_100M,
   input  logic        CLK_RST,
   input  logic        ADS_INIT_OK,
   input  logic        SAMPLE_EN,
   input  logic        MODE_CONT,
   input  logic [15:0] LINE_NUM,
   input  logic [2:0]  PGA_SEL,
   output logic        AFE_CLK,
   output logic        AFE_INTG,
   output logic        AFE_TFT,
   output logic        AFE_IRST,
   output logic        AFE_SHS,
   output logic        AFE_SHR,
   output logic        AFE_STI,
   output logic        AFE_DF_SM,
   output logic        AFE_PDZ,
   output logic        AFE_NAPZ,
   output logic        AFE_ENTRI,
   output logic        AFE_SMT_MD,
   output logic        AFE_INPUTZ,
   output logic [2:0]  AFE_PGA,
   input  logic        AFE_STO,
   output logic        BUSY,
   output logic        LINE_DONE,
   output logic        FRAME_DONE,
   output logic [15:0] LINE_IDX,
   output logic        STO_ERR
);

   localparam int N_HALF = 2 * CH_NUM * AFE_NUM;

   localparam logic [CNT_W-1:0] SXX_LEN   = CNT_W'(T_SXX);
   localparam logic [CNT_W-1:0] IRST_LAST = CNT_W'(T_IRST - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(T_HALF_CLK - 1);
   localparam logic [CNT_W-1:0] NHALF_LAST = CNT_W'(N_HALF - 1);
   localparam logic [CNT_W-1:0] SHR_LAST  = CNT_W'(T_WAIT_INTG - 1);
   localparam logic [CNT_W-1:0] INTG_LAST = CNT_W'(T_INTG + T_WAIT_SHS - 1);
   localparam logic [CNT_W-1:0] INTG_LEN  = CNT_W'(T_INTG);
   localparam logic [CNT_W-1:0] TFT_LEN   = CNT_W'(T_TFT);
   localparam logic [CNT_W-1:0] SHS_LAST  = CNT_W'(T_SXX + T_END - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IRST = 3'd1,
      ST_CLK  = 3'd2,
      ST_SHR  = 3'd3,
      ST_INTG = 3'd4,
      ST_SHS  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             sample_en_q, sample_en_d;
   logic             mode_cont_q, mode_cont_d;
   logic [15:0]      line_last_q, line_last_d;
   logic [15:0]      line_idx_q, line_idx_d;
   logic [2:0]       pga_q, pga_d;
   logic             line_end, frame_end, bad_state;

   logic             afe_clk_q, afe_clk_d;
   logic             afe_intg_q, afe_intg_d;
   logic             afe_tft_q, afe_tft_d;
   logic             afe_irst_q, afe_irst_d;
   logic             afe_shs_q, afe_shs_d;
   logic             afe_shr_q, afe_shr_d;
   logic             afe_sti_q, afe_sti_d;
   logic             afe_df_sm_q, afe_df_sm_d;
   logic             busy_q, busy_d;
   logic             line_done_q, line_done_d;
   logic             frame_done_q, frame_done_d;
   logic [15:0]      line_idx_out_q, line_idx_out_d;

   // Phase sequencing; every output below is decoded from this state one cycle later.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      sample_en_d = SAMPLE_EN;
      mode_cont_d = mode_cont_q;
      line_last_d = line_last_q;
      line_idx_d  = line_idx_q;
      pga_d       = pga_q;
      line_end    = 1'b0;
      frame_end   = 1'b0;
      bad_state   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            half_d = '0;
            if (SAMPLE_EN && !sample_en_q && ADS_INIT_OK) begin
               state_d     = ST_IRST;
               mode_cont_d = MODE_CONT;
               line_last_d = (LINE_NUM == 16'd0) ? 16'd0 : LINE_NUM - 16'd1;
               pga_d       = PGA_SEL;
               line_idx_d  = '0;
            end
         end
         ST_IRST: begin
            if (cnt_q == IRST_LAST) begin
               cnt_d   = '0;
               half_d  = '0;
               state_d = ST_CLK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLK: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (half_q == NHALF_LAST) begin
                  half_d  = '0;
                  state_d = ST_SHR;
               end else begin
                  half_d = half_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHR: begin
            if (cnt_q == SHR_LAST) begin
               cnt_d   = '0;
               state_d = ST_INTG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_INTG: begin
            if (cnt_q == INTG_LAST) begin
               cnt_d   = '0;
               state_d = ST_SHS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHS: begin
            if (cnt_q == SHS_LAST) begin
               cnt_d    = '0;
               line_end = 1'b1;
               // Continuous frames chain straight into the next IRST with no idle gap.
               if (mode_cont_q && (line_idx_q < line_last_q) && ADS_INIT_OK) begin
                  line_idx_d = line_idx_q + 16'd1;
                  state_d    = ST_IRST;
               end else begin
                  frame_end = 1'b1;
                  state_d   = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            bad_state  = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = '0;
            half_d     = '0;
            line_idx_d = '0;
            pga_d      = 3'b111;
         end
      endcase
   end

   always_comb begin
      afe_clk_d      = 1'b0;
      afe_intg_d     = 1'b0;
      afe_tft_d      = 1'b0;
      afe_irst_d     = 1'b0;
      afe_shs_d      = 1'b0;
      afe_shr_d      = 1'b0;
      afe_sti_d      = 1'b0;
      afe_df_sm_d    = 1'b1;
      busy_d         = 1'b0;
      line_done_d    = line_end;
      frame_done_d   = frame_end;
      line_idx_out_d = bad_state ? 16'd0 : line_idx_q;
      case (state_q)
         ST_IRST: begin
            busy_d     = 1'b1;
            afe_irst_d = 1'b1;
            afe_sti_d  = (cnt_q < SXX_LEN);
         end
         ST_CLK: begin
            busy_d    = 1'b1;
            afe_clk_d = ~half_q[0];
         end
         ST_SHR: begin
            busy_d    = 1'b1;
            afe_shr_d = (cnt_q < SXX_LEN);
         end
         ST_INTG: begin
            busy_d      = 1'b1;
            afe_intg_d  = (cnt_q < INTG_LEN);
            afe_tft_d   = (cnt_q < TFT_LEN);
            afe_df_sm_d = ~(cnt_q < TFT_LEN);
         end
         ST_SHS: begin
            busy_d    = 1'b1;
            afe_shs_d = (cnt_q < SXX_LEN);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK_100M) begin
      if (CLK_RST) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         half_q         <= '0;
         sample_en_q    <= 1'b0;
         mode_cont_q    <= 1'b0;
         line_last_q    <= '0;
         line_idx_q     <= '0;
         pga_q          <= 3'b111;
         afe_clk_q      <= 1'b0;
         afe_intg_q     <= 1'b0;
         afe_tft_q      <= 1'b0;
         afe_irst_q     <= 1'b0;
         afe_shs_q      <= 1'b0;
         afe_shr_q      <= 1'b0;
         afe_sti_q      <= 1'b0;
         afe_df_sm_q    <= 1'b1;
         busy_q         <= 1'b0;
         line_done_q    <= 1'b0;
         frame_done_q   <= 1'b0;
         line_idx_out_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         half_q         <= half_d;
         sample_en_q    <= sample_en_d;
         mode_cont_q    <= mode_cont_d;
         line_last_q    <= line_last_d;
         line_idx_q     <= line_idx_d;
         pga_q          <= pga_d;
         afe_clk_q      <= afe_clk_d;
         afe_intg_q     <= afe_intg_d;
         afe_tft_q      <= afe_tft_d;
         afe_irst_q     <= afe_irst_d;
         afe_shs_q      <= afe_shs_d;
         afe_shr_q      <= afe_shr_d;
         afe_sti_q      <= afe_sti_d;
         afe_df_sm_q    <= afe_df_sm_d;
         busy_q         <= busy_d;
         line_done_q    <= line_done_d;
         frame_done_q   <= frame_done_d;
         line_idx_out_q <= line_idx_out_d;
      end
   end

`ifdef AFE_SEQ_STO_CHECK_EN
   logic sto_seen_q, sto_seen_d;
   logic sto_err_q, sto_err_d;
   logic sto_out_q, sto_out_d;

   // Sticky error if the chain never shifted out during a CLK phase; cleared by an accepted start.
   always_comb begin
      sto_seen_d = sto_seen_q;
      sto_err_d  = sto_err_q;
      if (state_q == ST_IRST) begin
         sto_seen_d = 1'b0;
      end
      if (state_q == ST_CLK) begin
         sto_seen_d = sto_seen_q | AFE_STO;
         if ((cnt_q == HALF_LAST) && (half_q == NHALF_LAST)) begin
            sto_err_d = sto_err_q | ~(sto_seen_q | AFE_STO);
         end
      end
      if (((state_q == ST_IDLE) && (state_d == ST_IRST)) || bad_state) begin
         sto_err_d = 1'b0;
      end
      sto_out_d = bad_state ? 1'b0 : sto_err_q;
   end

   always_ff @(posedge CLK_100M) begin
      if (CLK_RST) begin
         sto_seen_q <= 1'b0;
         sto_err_q  <= 1'b0;
         sto_out_q  <= 1'b0;
      end else begin
         sto_seen_q <= sto_seen_d;
         sto_err_q  <= sto_err_d;
         sto_out_q  <= sto_out_d;
      end
   end

   assign STO_ERR = sto_out_q;
`else
   logic unused_sto;
   assign unused_sto = AFE_STO;
   assign STO_ERR    = 1'b0;
`endif

   assign AFE_CLK    = afe_clk_q;
   assign AFE_INTG   = afe_intg_q;
   assign AFE_TFT    = afe_tft_q;
   assign AFE_IRST   = afe_irst_q;
   assign AFE_SHS    = afe_shs_q;
   assign AFE_SHR    = afe_shr_q;
   assign AFE_STI    = afe_sti_q;
   assign AFE_DF_SM  = afe_df_sm_q;
   assign AFE_PDZ    = 1'b1;
   assign AFE_NAPZ   = 1'b1;
   assign AFE_ENTRI  = 1'b1;
   assign AFE_SMT_MD = 1'b1;
   assign AFE_INPUTZ = 1'b0;
   assign AFE_PGA    = pga_q;
   assign BUSY       = busy_q;
   assign LINE_DONE  = line_done_q;
   assign FRAME_DONE = frame_done_q;
   assign LINE_IDX   = line_idx_out_q;

endmodule

// File: tb/tb_afe_seq_ctl.sv
// Bench for afe_seq_ctl with shortened timing parameters; expected waveforms come from the
// phase-length arithmetic of a line, compared every cycle of each frame.
module tb_afe_seq_ctl;

   localparam int CH_NUM      = 4;
   localparam int AFE_NUM     = 2;
   localparam int T_SXX       = 2;
   localparam int T_IRST      = 4;
   localparam int T_HALF_CLK  = 3;
   localparam int T_WAIT_INTG = 3;
   localparam int T_TFT       = 7;
   localparam int T_INTG      = 9;
   localparam int T_WAIT_SHS  = 5;
   localparam int T_END       = 3;

   // Line offsets where each phase begins, and the total line length.
   localparam int N   = CH_NUM * AFE_NUM;
   localparam int P0  = T_IRST;
   localparam int P1  = P0 + 2 * N * T_HALF_CLK;
   localparam int P2  = P1 + T_WAIT_INTG;
   localparam int P3  = P2 + T_INTG + T_WAIT_SHS;
   localparam int LEN = P3 + T_SXX + T_END;

`ifdef AFE_SEQ_STO_CHECK_EN
   localparam bit STO_ON = 1'b1;
`else
   localparam bit STO_ON = 1'b0;
`endif

   logic        CLK_100M, CLK_RST, ADS_INIT_OK, SAMPLE_EN, MODE_CONT;
   logic [15:0] LINE_NUM;
   logic [2:0]  PGA_SEL;
   logic        AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM;
   logic        AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ;
   logic [2:0]  AFE_PGA;
   logic        AFE_STO;
   logic        BUSY, LINE_DONE, FRAME_DONE, STO_ERR;
   logic [15:0] LINE_IDX;

   int nPass;
   int nTotal;

   afe_seq_ctl #(
      .CH_NUM(CH_NUM), .AFE_NUM(AFE_NUM), .T_SXX(T_SXX), .T_IRST(T_IRST),
      .T_HALF_CLK(T_HALF_CLK), .T_WAIT_INTG(T_WAIT_INTG), .T_TFT(T_TFT),
      .T_INTG(T_INTG), .T_WAIT_SHS(T_WAIT_SHS), .T_END(T_END), .CNT_W(16)
   ) dut (
      .CLK_100M(CLK_100M), .CLK_RST(CLK_RST), .ADS_INIT_OK(ADS_INIT_OK),
      .SAMPLE_EN(SAMPLE_EN), .MODE_CONT(MODE_CONT), .LINE_NUM(LINE_NUM),
      .PGA_SEL(PGA_SEL), .AFE_CLK(AFE_CLK), .AFE_INTG(AFE_INTG), .AFE_TFT(AFE_TFT),
      .AFE_IRST(AFE_IRST), .AFE_SHS(AFE_SHS), .AFE_SHR(AFE_SHR), .AFE_STI(AFE_STI),
      .AFE_DF_SM(AFE_DF_SM), .AFE_PDZ(AFE_PDZ), .AFE_NAPZ(AFE_NAPZ),
      .AFE_ENTRI(AFE_ENTRI), .AFE_SMT_MD(AFE_SMT_MD), .AFE_INPUTZ(AFE_INPUTZ),
      .AFE_PGA(AFE_PGA), .AFE_STO(AFE_STO), .BUSY(BUSY), .LINE_DONE(LINE_DONE),
      .FRAME_DONE(FRAME_DONE), .LINE_IDX(LINE_IDX), .STO_ERR(STO_ERR)
   );

   initial CLK_100M = 1'b0;
   always #5 CLK_100M = ~CLK_100M;

   // Control bits {clk,intg,tft,irst,shs,shr,sti,df_sm} expected at offset t within a line.
   function automatic logic [7:0] expCtl(input int t);
      logic [7:0] v;
      v = 8'b0000_0001;
      if (t < P0) begin
         v[4] = 1'b1;
         v[1] = (t < T_SXX);
      end else if (t < P1) begin
         v[7] = (((t - P0) / T_HALF_CLK) % 2) == 0;
      end else if (t < P2) begin
         v[2] = (t - P1) < T_SXX;
      end else if (t < P3) begin
         v[6] = (t - P2) < T_INTG;
         v[5] = (t - P2) < T_TFT;
         v[0] = !((t - P2) < T_TFT);
      end else begin
         v[3] = (t - P3) < T_SXX;
      end
      return v;
   endfunction

   function automatic logic [35:0] mkVec(input logic [7:0] ctl, input logic busy, input logic ld,
                                         input logic fd, input logic [15:0] idx,
                                         input logic [2:0] pga, input logic sto);
      return {ctl, busy, ld, fd, idx, pga, sto, 4'b1111, 1'b0};
   endfunction

   function automatic logic [35:0] obsVec();
      return {AFE_CLK, AFE_INTG, AFE_TFT, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM,
              BUSY, LINE_DONE, FRAME_DONE, LINE_IDX, AFE_PGA, STO_ERR,
              AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ};
   endfunction

   logic [35:0] resetVec;

   task automatic checkOutput(input string tag, input int cyc, input logic [35:0] obs,
                              input logic [35:0] expv);
      nTotal++;
      assert (obs === expv) nPass++;
      else $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
   endtask

   task automatic applyStimulus(input bit mode, input logic [15:0] lnum, input logic [2:0] pga,
                                input bit sen);
      @(negedge CLK_100M);
      MODE_CONT = mode;
      LINE_NUM  = lnum;
      PGA_SEL   = pga;
      SAMPLE_EN = sen;
   endtask

   // Start a frame and check every cycle; optional mid-frame poke, ADS drop or reset abort.
   task automatic runFrame(input string tag, input bit mode, input logic [15:0] lnum,
                           input logic [2:0] pga, input bit stoPulse, input int adsDrop,
                           input int poke, input int abort);
      int lines, total, line, t;
      logic stoExp;
      logic [35:0] e;
      lines = mode ? ((lnum == 16'd0) ? 1 : int'(lnum)) : 1;
      if (adsDrop >= 0 && (adsDrop / LEN + 1) < lines) lines = adsDrop / LEN + 1;
      total  = lines * LEN;
      stoExp = 1'b0;
      applyStimulus(mode, lnum, pga, 1'b1);
      @(negedge CLK_100M);
      SAMPLE_EN = 1'b0;
      checkOutput({tag, "_latency"}, -1, {32'd0, BUSY, AFE_PGA}, {32'd0, 1'b0, pga});
      for (int c = 0; c < total; c++) begin
         @(negedge CLK_100M);
         line   = c / LEN;
         t      = c % LEN;
         stoExp = STO_ON && !stoPulse && (line > 0 || t >= P1);
         e = mkVec(expCtl(t), 1'b1, t == LEN - 1, c == total - 1, 16'(line), pga, stoExp);
         checkOutput(tag, c, obsVec(), e);
         if (c == abort) begin
            CLK_RST = 1'b1;
            break;
         end
         if (stoPulse) AFE_STO = (t == P0 + 5);
         if (c == poke) begin
            SAMPLE_EN = 1'b1;
            PGA_SEL   = ~pga;
            MODE_CONT = ~mode;
            LINE_NUM  = 16'd0;
         end
         if (c == poke + 1) SAMPLE_EN = 1'b0;
         if (c == adsDrop) ADS_INIT_OK = 1'b0;
      end
      @(negedge CLK_100M);
      if (abort >= 0) begin
         checkOutput({tag, "_reset"}, abort, obsVec(), resetVec);
         CLK_RST = 1'b0;
      end else begin
         checkOutput({tag, "_idle"}, total, obsVec(),
                     mkVec(8'b0000_0001, 1'b0, 1'b0, 1'b0, 16'(lines - 1), pga, stoExp));
      end
      ADS_INIT_OK = 1'b1;
      SAMPLE_EN   = 1'b0;
      AFE_STO     = 1'b0;
      PGA_SEL     = pga;
   endtask

   initial begin
      logic [2:0] pga;
      nPass       = 0;
      nTotal      = 0;
      resetVec    = mkVec(8'b0000_0001, 1'b0, 1'b0, 1'b0, 16'd0, 3'b111, 1'b0);
      CLK_RST     = 1'b1;
      ADS_INIT_OK = 1'b1;
      SAMPLE_EN   = 1'b0;
      MODE_CONT   = 1'b0;
      LINE_NUM    = 16'd0;
      PGA_SEL     = 3'b000;
      AFE_STO     = 1'b0;
      repeat (3) @(negedge CLK_100M);
      checkOutput("reset", 0, obsVec(), resetVec);
      CLK_RST = 1'b0;
      @(negedge CLK_100M);
      checkOutput("reset_hold", 1, obsVec(), resetVec);

      $display("[TB] single-line frames");
      runFrame("single_nosto", 1'b0, 16'd5, 3'b011, 1'b0, -1, -1, -1);
      runFrame("single_sto", 1'b0, 16'd0, 3'b100, 1'b1, -1, -1, -1);
      for (int i = 0; i < 3; i++) begin
         runFrame("single_rand", 1'b0, 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), -1, -1, -1);
      end

      $display("[TB] continuous frames");
      runFrame("cont3_poke", 1'b1, 16'd3, 3'b010, 1'b1, -1, LEN + 30, -1);
      for (int i = 0; i < 3; i++) begin
         runFrame("cont_rand", 1'b1, 16'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), -1, -1, -1);
      end
      runFrame("ads_drop", 1'b1, 16'd4, 3'($urandom_range(0, 7)), 1'b1, LEN + 20, -1, -1);

      $display("[TB] start ignored while ADC not ready");
      ADS_INIT_OK = 1'b0;
      @(negedge CLK_100M);
      SAMPLE_EN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK_100M);
         checkOutput("no_ads_start", i, {34'd0, BUSY, AFE_IRST}, 36'd0);
      end
      SAMPLE_EN = 1'b0;
      @(negedge CLK_100M);
      ADS_INIT_OK = 1'b1;
      @(negedge CLK_100M);
      checkOutput("no_ads_idle", 0, {34'd0, BUSY, AFE_IRST}, 36'd0);

      $display("[TB] reset during INTG, then fresh start");
      pga = 3'($urandom_range(0, 7));
      runFrame("rst_intg", 1'b1, 16'd2, pga, 1'b0, -1, -1, P2 + 4);
      runFrame("after_rst", 1'b0, 16'd1, 3'($urandom_range(0, 7)), 1'b1, -1, -1, -1);

      $display("[TB] shift-out check sequence");
      runFrame("sto_low", 1'b1, 16'd2, 3'b001, 1'b0, -1, -1, -1);
      runFrame("sto_pulsed", 1'b0, 16'd0, 3'b110, 1'b1, -1, -1, -1);

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
